// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer
//   Streams (a,b) operand beats into one dsp_t1_20x18x64 running in
//   accumulate mode and returns one dot-product result per vector.
//   The first beat of a vector bypasses the accumulator (load_acc plus
//   FB_FIRST). Every non-accept cycle drives zero operands, so the
//   accumulator holds its value. After the last beat the block waits out
//   the DSP pipeline, then presents the result on a valid/ready port.
//
// Ports
//   clock_i, reset_i             clock, synchronous active-low reset
//   s_valid_i/s_ready_o          operand beat handshake
//   s_a_i, s_b_i, s_last_i       operand beat payload
//   cfg_unsigned_a/b_i           operand signedness (sampled on first beat)
//   cfg_subtract_i               subtract products (sampled on first beat)
//   cfg_saturate_i               only with DSP_MAC_SAT_EN
//   m_valid_o/m_ready_i          result handshake
//   m_z_o, m_count_o, m_ovf_o    result, beat count, count saturated
//   busy_o                       sequencer not idle
//   dsp_*_o / dsp_z_i            registered DSP control and result return
//
// Build option
//   DSP_MAC_SAT_EN : adds cfg_saturate_i, which is latched on the first beat
//                    and driven onto dsp_saturate_o (otherwise tied 0).
module dsp_mac_sequencer #(
  parameter int          A_W      = 20,
  parameter int          B_W      = 18,
  parameter int          Z_W      = 38,
  parameter int          CNT_W    = 16,
  parameter int          DSP_LAT  = 1,
  parameter logic [2:0]  FB_FIRST = 3'd1,
  parameter logic [2:0]  FB_ACCUM = 3'd0,
  parameter logic [2:0]  OUT_SEL  = 3'd1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [A_W-1:0]   s_a_i,
  input  logic [B_W-1:0]   s_b_i,
  input  logic             s_last_i,
  input  logic             cfg_unsigned_a_i,
  input  logic             cfg_unsigned_b_i,
  input  logic             cfg_subtract_i,
`ifdef DSP_MAC_SAT_EN
  input  logic             cfg_saturate_i,
`endif
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [Z_W-1:0]   m_z_o,
  output logic [CNT_W-1:0] m_count_o,
  output logic             m_ovf_o,
  output logic             busy_o,
  output logic [A_W-1:0]   dsp_a_o,
  output logic [B_W-1:0]   dsp_b_o,
  output logic             dsp_load_acc_o,
  output logic [2:0]       dsp_feedback_o,
  output logic [2:0]       dsp_output_select_o,
  output logic             dsp_unsigned_a_o,
  output logic             dsp_unsigned_b_o,
  output logic             dsp_subtract_o,
  output logic             dsp_saturate_o,
  input  logic [Z_W-1:0]   dsp_z_i
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_OUTPUT = 2'd3;

  // Capture happens DSP_LAT+2 edges after the last accept: one edge for the
  // operand register, DSP_LAT for the DSP, one of margin for the
  // accumulator to settle behind zero-operand bubbles.
  localparam logic [3:0]       DRAIN_LAST = 4'(DSP_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  logic [1:0]       r_state;
  logic [3:0]       r_drain;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_mvalid;
  logic [Z_W-1:0]   r_mz;
  logic [A_W-1:0]   r_dsp_a;
  logic [B_W-1:0]   r_dsp_b;
  logic             r_load;
  logic [2:0]       r_fb;
  logic [2:0]       r_osel;
  logic             r_ua;
  logic             r_ub;
  logic             r_sub;
  logic             r_sat;

  logic w_ready;
  logic w_accept;
  logic w_first;
  logic w_sat_cfg;

`ifdef DSP_MAC_SAT_EN
  assign w_sat_cfg = cfg_saturate_i;
`else
  assign w_sat_cfg = 1'b0;
`endif

  assign w_ready  = (r_state == S_IDLE) || (r_state == S_ACCUM);
  assign w_accept = s_valid_i && w_ready;
  assign w_first  = w_accept && (r_state == S_IDLE);

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      r_state  <= S_IDLE;
      r_drain  <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_mvalid <= 1'b0;
      r_mz     <= '0;
      r_dsp_a  <= '0;
      r_dsp_b  <= '0;
      r_load   <= 1'b0;
      r_fb     <= FB_ACCUM;
      r_osel   <= 3'd0;
      r_ua     <= 1'b0;
      r_ub     <= 1'b0;
      r_sub    <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      // Zero operands on every non-accept cycle keep the accumulator still.
      r_dsp_a <= '0;
      r_dsp_b <= '0;
      r_load  <= 1'b0;
      r_fb    <= FB_ACCUM;
      r_osel  <= OUT_SEL;

      if (w_accept) begin
        r_dsp_a <= s_a_i;
        r_dsp_b <= s_b_i;
        if (w_first) begin
          r_load <= 1'b1;
          r_fb   <= FB_FIRST;
          r_ua   <= cfg_unsigned_a_i;
          r_ub   <= cfg_unsigned_b_i;
          r_sub  <= cfg_subtract_i;
          r_sat  <= w_sat_cfg;
          r_cnt  <= {{(CNT_W-1){1'b0}}, 1'b1};
          r_ovf  <= 1'b0;
        end else if (r_cnt == CNT_MAX) begin
          r_ovf <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (w_accept) begin
            r_state <= s_last_i ? S_DRAIN : S_ACCUM;
            r_drain <= '0;
          end
        end
        S_DRAIN: begin
          if (r_drain == DRAIN_LAST) begin
            r_mz     <= dsp_z_i;
            r_mvalid <= 1'b1;
            r_state  <= S_OUTPUT;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        S_OUTPUT: begin
          if (m_ready_i) begin
            r_mvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_ready_o           = w_ready;
  assign busy_o              = (r_state != S_IDLE);
  assign m_valid_o           = r_mvalid;
  assign m_z_o               = r_mz;
  assign m_count_o           = r_cnt;
  assign m_ovf_o             = r_ovf;
  assign dsp_a_o             = r_dsp_a;
  assign dsp_b_o             = r_dsp_b;
  assign dsp_load_acc_o      = r_load;
  assign dsp_feedback_o      = r_fb;
  assign dsp_output_select_o = r_osel;
  assign dsp_unsigned_a_o    = r_ua;
  assign dsp_unsigned_b_o    = r_ub;
  assign dsp_subtract_o      = r_sub;
  assign dsp_saturate_o      = r_sat;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural one-cycle DSP
// accumulator model. CNT_W is shrunk to 2 so count saturation is reachable.
module tb_dsp_mac_sequencer;

  localparam int A_W = 20, B_W = 18, Z_W = 38, CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s_valid, s_ready, s_last;
  logic [A_W-1:0]   s_a;
  logic [B_W-1:0]   s_b;
  logic             cfg_ua, cfg_ub, cfg_sub;
  logic             m_valid, m_ready, m_ovf, busy;
  logic [Z_W-1:0]   m_z;
  logic [CNT_W-1:0] m_count;
  logic [A_W-1:0]   dsp_a;
  logic [B_W-1:0]   dsp_b;
  logic             dsp_load, dsp_ua, dsp_ub, dsp_sub, dsp_sat;
  logic [2:0]       dsp_fb, dsp_osel;
  logic [Z_W-1:0]   dsp_z;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dsp_mac_sequencer #(.A_W(A_W), .B_W(B_W), .Z_W(Z_W), .CNT_W(CNT_W), .DSP_LAT(1)) dut (
    .clock_i(clk), .reset_i(rst_n),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_a_i(s_a), .s_b_i(s_b), .s_last_i(s_last),
    .cfg_unsigned_a_i(cfg_ua), .cfg_unsigned_b_i(cfg_ub), .cfg_subtract_i(cfg_sub),
`ifdef DSP_MAC_SAT_EN
    .cfg_saturate_i(1'b0),
`endif
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_z_o(m_z), .m_count_o(m_count), .m_ovf_o(m_ovf),
    .busy_o(busy),
    .dsp_a_o(dsp_a), .dsp_b_o(dsp_b), .dsp_load_acc_o(dsp_load), .dsp_feedback_o(dsp_fb),
    .dsp_output_select_o(dsp_osel), .dsp_unsigned_a_o(dsp_ua), .dsp_unsigned_b_o(dsp_ub),
    .dsp_subtract_o(dsp_sub), .dsp_saturate_o(dsp_sat), .dsp_z_i(dsp_z)
  );

  // DSP model: one register stage; load_acc restarts, otherwise accumulates.
  always @(posedge clk) begin : dsp_model
    longint av, bv, p;
    av = dsp_ua ? longint'(dsp_a) : longint'($signed(dsp_a));
    bv = dsp_ub ? longint'(dsp_b) : longint'($signed(dsp_b));
    p  = av * bv;
    if (dsp_sub) p = -p;
    if (!rst_n)        dsp_z <= '0;
    else if (dsp_load) dsp_z <= Z_W'(p);
    else               dsp_z <= dsp_z + Z_W'(p);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Presents one beat and returns #1 after the edge that accepted it.
  task automatic send(input logic [A_W-1:0] a, input logic [B_W-1:0] b, input logic last);
    int n = 0;
    s_valid = 1'b1; s_a = a; s_b = b; s_last = last;
    while (!s_ready && n < 50) begin step(); n++; end
    if (n == 50) chk("send_timeout", 64'd0, 64'd1);
    step();
    s_valid = 1'b0; s_last = 1'b0; s_a = '0; s_b = '0;
  endtask

  task automatic wait_mvalid();
    int n = 0;
    while (!m_valid && n < 20) begin step(); n++; end
    if (n == 20) chk("result_timeout", 64'd0, 64'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [Z_W-1:0] ez, z0;
    rst_n = 1'b0; s_valid = 1'b1; s_a = 20'd7; s_b = 18'd7; s_last = 1'b0;
    cfg_ua = 1'b0; cfg_ub = 1'b0; cfg_sub = 1'b0; m_ready = 1'b1;

    // Reset held 3 cycles with a beat offered: nothing may be accepted.
    repeat (3) step();
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dsp_a", dsp_a, 0);
    chk("rst_load", dsp_load, 0);
    chk("rst_fb", dsp_fb, 0);
    chk("rst_osel", dsp_osel, 0);
    s_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("idle_osel", dsp_osel, 1);
    chk("idle_busy", busy, 0);

    // Vector 1: 3*4 + 5*6 + (-2)*7 = 28; count 3 is exactly CNT max.
    send(20'd3, 18'd4, 1'b0);
    chk("v1_fb_first", dsp_fb, 1);
    chk("v1_load_first", dsp_load, 1);
    chk("v1_dsp_a", dsp_a, 3);
    cfg_ua = 1'b1;                       // mid-vector change must be ignored
    send(20'd5, 18'd6, 1'b0);
    chk("v1_fb_accum", dsp_fb, 0);
    chk("v1_load_next", dsp_load, 0);
    chk("v1_cfg_ignored", dsp_ua, 0);
    send(-20'sd2, 18'd7, 1'b1);
    chk("v1_busy", busy, 1);
    chk("v1_not_ready", s_ready, 0);
    step(); chk("v1_lat1", m_valid, 0);
    step(); chk("v1_lat2", m_valid, 0);
    step(); chk("v1_lat3", m_valid, 1);
    chk("v1_z", m_z, 28);
    chk("v1_count", m_count, 3);
    chk("v1_ovf", m_ovf, 0);
    cfg_ua = 1'b0;
    step(); chk("v1_handshake", m_valid, 0);

    // Saturation: five beats of (1,1) -> z=5, count pinned at 3 with ovf.
    repeat (4) send(20'd1, 18'd1, 1'b0);
    send(20'd1, 18'd1, 1'b1);
    wait_mvalid();
    chk("sat_z", m_z, 5);
    chk("sat_count", m_count, 3);
    chk("sat_ovf", m_ovf, 1);
    step();

    // Single-beat vector: first and last at once.
    send(20'd100, -18'sd3, 1'b1);
    chk("sb_load", dsp_load, 1);
    step();
    chk("sb_load_clr", dsp_load, 0);
    wait_mvalid();
    ez = -300;
    chk("sb_z", m_z, ez);
    chk("sb_count", m_count, 1);
    chk("sb_ovf_clr", m_ovf, 0);
    step();

    // Backpressure: 7*8=56 held for 10 cycles with m_ready low.
    m_ready = 1'b0;
    send(20'd7, 18'd8, 1'b1);
    wait_mvalid();
    z0 = m_z;
    chk("bp_z", m_z, 56);
    repeat (10) begin
      step();
      chk("bp_valid", m_valid, 1);
      chk("bp_z_stable", m_z, z0);
      chk("bp_not_ready", s_ready, 0);
    end
    // Offer the next vector's first beat together with the handshake.
    m_ready = 1'b1; s_valid = 1'b1; s_a = 20'd2; s_b = 18'd2; s_last = 1'b0;
    step();
    chk("bp_hs_valid", m_valid, 0);
    chk("bp_hs_ready", s_ready, 1);
    chk("bp_hs_no_accept", dsp_a, 0);
    step();
    s_valid = 1'b0;
    chk("bp_next_a", dsp_a, 2);
    chk("bp_next_load", dsp_load, 1);

    // Bubbles: 4 idle cycles mid-vector feed zeros; 2*2 + 3*3 = 13.
    repeat (4) begin
      step();
      chk("bub_a_zero", dsp_a, 0);
      chk("bub_b_zero", dsp_b, 0);
      chk("bub_busy", busy, 1);
    end
    send(20'd3, 18'd3, 1'b1);
    wait_mvalid();
    chk("bub_z", m_z, 13);
    chk("bub_count", m_count, 2);
    step();

    // Abort: reset during DRAIN suppresses the result.
    send(20'd5, 18'd5, 1'b1);
    step();
    chk("ab_busy", busy, 1);
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    chk("ab_idle", busy, 0);
    repeat (6) begin step(); chk("ab_no_valid", m_valid, 0); end
    send(20'd1, 18'd1, 1'b1);
    wait_mvalid();
    chk("ab_z", m_z, 1);
    chk("ab_count", m_count, 1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
